// File: rtl/ids_lab01_pkg.sv
// Shared definitions for the lab-01 button conditioner: per-channel FSM
// state encoding and the default debounce parameters.
package ids_lab01_pkg;

    typedef enum logic [1:0] {
        ST_LO      = 2'd0,
        ST_WAIT_HI = 2'd1,
        ST_HI      = 2'd2,
        ST_WAIT_LO = 2'd3
    } state_t;

    // 10 ms at 50 MHz
    localparam int DEFAULT_DEBOUNCE_CYC = 500000;
    localparam int DEFAULT_CNT_W        = 20;

endpackage

// File: rtl/ids_lab01_debounce_ch.sv
// One button channel: two-flop synchronizer, stability counter, four-state
// debounce FSM, registered level and registered one-cycle edge strobes.
module ids_lab01_debounce_ch
    import ids_lab01_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEFAULT_DEBOUNCE_CYC,
    parameter int CNT_W        = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s1;
    logic             s2;
    state_t           state;
    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values; blocking here would collapse s1/s2 into one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Strobes default low every cycle so they can only ever be one cycle wide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_LO;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
                ST_LO: begin
                    if (s2) begin
                        if (DEBOUNCE_CYC == 1) begin
                            state <= ST_HI;
                            level <= 1'b1;
                            rise  <= 1'b1;
                        end else begin
                            state <= ST_WAIT_HI;
                            cnt   <= CNT_ONE;
                        end
                    end
                end
                ST_WAIT_HI: begin
                    if (!s2) begin
                        state <= ST_LO;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= ST_HI;
                        cnt   <= '0;
                        level <= 1'b1;
                        rise  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_HI: begin
                    if (!s2) begin
                        if (DEBOUNCE_CYC == 1) begin
                            state <= ST_LO;
                            level <= 1'b0;
                            fall  <= 1'b1;
                        end else begin
                            state <= ST_WAIT_LO;
                            cnt   <= CNT_ONE;
                        end
                    end
                end
                ST_WAIT_LO: begin
                    if (s2) begin
                        state <= ST_HI;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= ST_LO;
                        cnt   <= '0;
                        level <= 1'b0;
                        fall  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= ST_LO;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/ids_lab01_btn_conditioner.sv
// Lab board push-button conditioner: two identical, independent debounce
// channels mapping raw buttons C and D to clean levels and edge strobes.
module ids_lab01_btn_conditioner
    import ids_lab01_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEFAULT_DEBOUNCE_CYC,
    parameter int CNT_W        = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_c_raw,
    input  logic btn_d_raw,
    output logic c,
    output logic d,
    output logic c_rise,
    output logic c_fall,
    output logic d_rise,
    output logic d_fall
);

    ids_lab01_debounce_ch #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .CNT_W        (CNT_W)
    ) u_ch_c (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_c_raw),
        .level (c),
        .rise  (c_rise),
        .fall  (c_fall)
    );

    ids_lab01_debounce_ch #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .CNT_W        (CNT_W)
    ) u_ch_d (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_d_raw),
        .level (d),
        .rise  (d_rise),
        .fall  (d_fall)
    );

endmodule
